// File: rtl/rs232c_rx.sv
// rs232c_rx: 8N1 UART receiver with valid/ack handshake, framing-error pulse and sticky overrun
module rs232c_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [7:0] LED
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          half_hit, bit_hit;

  assign rxs      = sync_q[1];
  assign half_hit = cnt_q == CW'(HALF_BIT - 1);
  assign bit_hit  = cnt_q == CW'(CLKS_PER_BIT - 1);

  // Next-state: one counter reloaded at every sample point, no oversampling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = 1'b0;
    valid_d = valid_q & ~rx_ack;
    ovr_d   = ovr_q & ~rx_ack;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rxs ? IDLE : START;
      end
      START: if (half_hit) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (bit_hit) begin
        cnt_d          = '0;
        shift_d[idx_q] = rxs;
        idx_d          = idx_q + 3'd1;
        state_d        = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (bit_hit) begin
        cnt_d   = '0;
        state_d = rxs ? IDLE : BRK;
        if (rxs) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          ovr_d   = valid_q & ~rx_ack;
        end else begin
          ferr_d  = 1'b1;
        end
      end
      BRK: begin
        cnt_d   = '0;
        state_d = rxs ? IDLE : BRK;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronizer presets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rxdata    = data_q;
  assign LED       = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_rs232c_rx.sv
// tb_rs232c_rx: directed checks of rs232c_rx at 868 and 16 clocks per bit
module tb_rs232c_rx;
  logic       clk = 1'b0, rstn = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1, ack_a = 1'b0, ack_b = 1'b0;
  logic [7:0] data_a, data_b, led_a, led_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;
  int         n_assert = 0, n_fail = 0;
  int         fa = 0, fb = 0, va = 0;
  int         rise, busy_seen, f0, g_busy;

  always #5 clk = ~clk;

  rs232c_rx #(.CLKS_PER_BIT(868)) u_a (
    .clk(clk), .rstn(rstn), .uart_rxd(rxd_a), .rx_ack(ack_a), .rxdata(data_a),
    .rx_valid(valid_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a), .LED(led_a));

  rs232c_rx #(.CLKS_PER_BIT(16)) u_b (
    .clk(clk), .rstn(rstn), .uart_rxd(rxd_b), .rx_ack(ack_b), .rxdata(data_b),
    .rx_valid(valid_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b), .LED(led_b));

  always @(negedge clk) begin
    if (ferr_a) fa++;
    if (ferr_b) fb++;
    if (valid_a) va++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] fr(input logic [7:0] b, input logic s);
    return {s, b, 1'b0};
  endfunction

  task automatic drive(input bit sel, input int cpb, input logic [9:0] f, input int ncyc);
    rise = -1;
    busy_seen = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (sel) rxd_b = f[n / cpb]; else rxd_a = f[n / cpb];
      @(negedge clk);
      if (rise < 0 && (sel ? valid_b : valid_a)) rise = n + 1;
      if (sel ? busy_b : busy_a) busy_seen = 1;
    end
  endtask

  task automatic pulse_ack(input bit sel);
    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    chk("rst_rxdata", data_a, 8'h00);
    chk("rst_led", led_a, 8'h00);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_ovr", ovr_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ferr", ferr_a, 1'b0);
    repeat (20000) @(negedge clk);
    chk("idle_valid_cycles", va, 0);
    chk("idle_ferr_pulses", fa, 0);
    chk("idle_busy", busy_a, 1'b0);
    chk("idle_rxdata", data_a, 8'h00);

    drive(1'b0, 868, fr(8'hA5, 1'b1), 8680);
    chk("a5_latency", rise, 8249);
    chk("a5_rxdata", data_a, 8'hA5);
    chk("a5_led", led_a, 8'hA5);
    chk("a5_valid", valid_a, 1'b1);
    chk("a5_ovr", ovr_a, 1'b0);
    repeat (100) @(negedge clk);
    chk("a5_hold", valid_a, 1'b1);
    pulse_ack(1'b0);
    chk("a5_ack_valid", valid_a, 1'b0);
    chk("a5_ack_data", data_a, 8'hA5);
    pulse_ack(1'b0);
    chk("ack_idle_valid", valid_a, 1'b0);

    f0 = fb;
    drive(1'b1, 16, fr(8'h00, 1'b1), 160);
    chk("b2b0_valid", valid_b, 1'b1);
    chk("b2b0_ovr", ovr_b, 1'b0);
    chk("b2b0_data", data_b, 8'h00);
    drive(1'b1, 16, fr(8'hFF, 1'b1), 160);
    chk("b2b1_ovr", ovr_b, 1'b1);
    chk("b2b1_data", data_b, 8'hFF);
    drive(1'b1, 16, fr(8'h3C, 1'b1), 160);
    chk("b2b2_data", data_b, 8'h3C);
    chk("b2b2_valid", valid_b, 1'b1);
    chk("b2b2_ovr", ovr_b, 1'b1);
    chk("b2b_no_ferr", fb - f0, 0);
    pulse_ack(1'b1);
    chk("b2b_ack_valid", valid_b, 1'b0);
    chk("b2b_ack_ovr", ovr_b, 1'b0);

    f0 = fb;
    drive(1'b1, 16, fr(8'h55, 1'b0), 160);
    drive(1'b1, 16, 10'h000, 640);
    chk("brk_busy", busy_b, 1'b1);
    chk("brk_ferr_count", fb - f0, 1);
    chk("brk_valid", valid_b, 1'b0);
    chk("brk_data", data_b, 8'h3C);
    rxd_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("brk_release_busy", busy_b, 1'b0);
    drive(1'b1, 16, fr(8'h81, 1'b1), 160);
    chk("post_brk_data", data_b, 8'h81);
    chk("post_brk_valid", valid_b, 1'b1);
    chk("post_brk_ferr", fb - f0, 1);
    pulse_ack(1'b1);

    f0 = fb;
    drive(1'b1, 16, 10'h000, 6);
    g_busy = busy_seen;
    drive(1'b1, 16, 10'h3FF, 20);
    chk("glitch_busy_seen", g_busy, 1);
    chk("glitch_busy_end", busy_b, 1'b0);
    chk("glitch_valid", valid_b, 1'b0);
    chk("glitch_ferr", fb - f0, 0);

    drive(1'b1, 16, fr(8'hC3, 1'b1), 16 * 5 + 8);
    rstn = 1'b0;
    rxd_b = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("midrst_busy", busy_b, 1'b0);
    chk("midrst_valid", valid_b, 1'b0);
    chk("midrst_data", data_b, 8'h00);
    repeat (20) @(negedge clk);
    chk("midrst_no_valid", valid_b, 1'b0);
    drive(1'b1, 16, fr(8'h12, 1'b1), 160);
    chk("after_rst_data", data_b, 8'h12);
    chk("after_rst_led", led_b, 8'h12);
    chk("after_rst_valid", valid_b, 1'b1);
    chk("after_rst_ovr", ovr_b, 1'b0);
    chk("after_rst_ferr", fb - f0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rs232c_rx.md
Name: rs232c_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the board's RS232C transmit path.
- Samples the asynchronous `uart_rxd` pin, recovers bytes (LSB first), and presents each byte to the fabric with a valid/ack handshake.
- Flags framing errors and overruns.
- Sits between the FTDI/USB-UART pin and the command/readout logic; same 100 MHz SYSCLK, same 115200 bps default.

Parameters:
- CLKS_PER_BIT, 868, SYSCLK cycles per bit (100 MHz / 115200). Must be ≥ 8.
- HALF_BIT, CLKS_PER_BIT/2 (434), cycles from detected start edge to the start-bit mid-point sample.

Ports:
- clk  in  1  system clock, 100 MHz
- rstn  in  1  synchronous active-low reset, sampled on posedge clk
- uart_rxd  in  1  asynchronous serial input, idle high
- rx_ack  in  1  consumer acknowledge; clears rx_valid
- rxdata  out  8  last good received byte, held until the next good byte
- rx_valid  out  1  level; high while rxdata holds an unacknowledged byte
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky; a new byte completed while rx_valid was high; cleared by rx_ack or reset
- busy  out  1  high in any state other than IDLE
- LED  out  8  mirror of rxdata, for bring-up

Behaviour:
- Reset (rstn=0 at posedge clk):
  - state=IDLE, counters=0, shift register=0.
  - rxdata=0, rx_valid=0, frame_err=0, overrun=0, busy=0, LED=0.
  - Synchronizer flops are preset to 1.
  - Reset mid-frame abandons the frame; no valid or error pulse is produced.
- Input synchronization:
  - uart_rxd passes through a 2-FF synchronizer; only the synchronized value (rxs) is used.
  - This adds 2 cycles of latency, which is excluded from the timings below.
- Sample timing: let T0 be the cycle IDLE sees rxs=0.
  - Sample k (k=0 start, k=1..8 data bit k-1, k=9 stop) is taken at T0 + HALF_BIT + k*CLKS_PER_BIT.
  - One cycle counter is used, reloaded at each sample. No oversampling or majority vote.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE, plus BREAK.
  - IDLE: wait for rxs=0, then go to START with counter cleared.
  - START: at sample 0:
    - rxs=0: go to DATA, bit index=0.
    - rxs=1: treat as a glitch and return to IDLE with no outputs.
  - DATA: at each sample, shift rxs into bit [index], LSB first. After index 7, go to STOP.
  - STOP: at sample 9:
    - rxs=1: rxdata<=shift, LED<=shift, rx_valid<=1. If rx_valid was already 1 and rx_ack is not asserted that cycle, also overrun<=1; new data overwrites the old. Return to IDLE.
    - rxs=0: frame_err pulses for 1 cycle. rxdata, rx_valid and overrun are unchanged. Go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Latency: rx_valid rises at T0 + HALF_BIT + 9*CLKS_PER_BIT + 1. This is mid-stop-bit, so back-to-back frames are received with no gap.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid and overrun on the next edge.
  - rx_ack while rx_valid=0 has no effect.
  - rx_ack in the same cycle as a new byte completing: the new byte wins, rx_valid stays 1, overrun stays 0.
- busy=1 in START, DATA, STOP and BREAK.

Test Plan:
- Reset then idle: hold rstn=0 for 4 cycles, line high for 20000 cycles -> all outputs 0, busy 0, no pulses.
- Single byte, default CLKS_PER_BIT=868: send 0xA5 (start, 10100101 LSB-first, stop) -> rx_valid rises at T0+434+7812+1 = T0+8247 (before synchronizer delay). rxdata=LED=0xA5. Hold it; after rx_ack, rx_valid=0.
- Back-to-back with CLKS_PER_BIT=16, no ack: send 0x00, 0xFF, 0x3C contiguous ->
  - rx_valid stays 1, overrun=1 after the second byte, rxdata=0x3C at the end.
  - One rx_ack clears both rx_valid and overrun.
- Framing error and break: send 0x55 with stop bit 0, then hold the line low for 40 bit times, then high ->
  - exactly one frame_err pulse; rx_valid stays 0.
  - busy stays 1 until the line goes high, then 0.
  - A following 0x81 is received correctly.
- Glitch rejection: a low pulse of HALF_BIT-2 cycles on the idle line -> START aborts, no rx_valid, no frame_err, busy returns to 0.
- Reset mid-frame: assert rstn=0 during data bit 4 of 0xC3, release, then send 0x12 -> no output from the aborted frame; rxdata=0x12, rx_valid=1.
